// File: rtl/qupls_dram_sched_pkg.sv
// Shared types for the Qupls data-cache memory-slot scheduler.
package qupls_dram_sched_pkg;

  typedef enum logic [1:0] {
    DRAMSLOT_AVAIL  = 2'd0,
    DRAMSLOT_READY  = 2'd1,
    DRAMSLOT_ACTIVE = 2'd2,
    DRAMSLOT_DELAY  = 2'd3
  } dram_state_t;

  localparam int unsigned NDRAMSLOT = 2;

endpackage

// File: rtl/qupls_dram_sched_rr_arb.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances past the winner.
module qupls_dram_sched_rr_arb #(
  parameter int unsigned NREQ = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] grant_o
);
  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0] r_rr;
  logic [PW-1:0] w_rr_d;
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    grant_o = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_rr_d  = r_rr;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = PW'((32'(r_rr) + i) % NREQ);
      if (en_i && !w_found && req_i[w_idx]) begin
        w_found        = 1'b1;
        grant_o[w_idx] = 1'b1;
        w_rr_d         = PW'((32'(w_idx) + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_rr <= '0;
    else       r_rr <= w_rr_d;
  end

endmodule

// File: rtl/qupls_dram_sched.sv
// Memory-slot scheduler: arbitrates requesters into free slots and serialises
// READY slots onto the single data-cache bus, one ACTIVE slot at a time.
module qupls_dram_sched
  import qupls_dram_sched_pkg::*;
#(
  parameter int unsigned NSLOT = NDRAMSLOT,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned TAGW  = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*TAGW-1:0] req_tag_i,
  output logic [NREQ-1:0]      grant_o,
  output logic                 bus_cyc_o,
  output logic [1:0]           bus_slot_o,
  output logic [TAGW-1:0]      bus_tag_o,
  input  logic                 ack_i,
  input  logic                 flush_i,
  output logic                 done_o,
  output logic [1:0]           done_slot_o,
  output logic [TAGW-1:0]      done_tag_o,
  output logic [NSLOT*2-1:0]   slot_state_o
);
  dram_state_t     r_state   [NSLOT];
  dram_state_t     w_state_d [NSLOT];
  logic [TAGW-1:0] r_tag     [NSLOT];
  logic [TAGW-1:0] w_tag_d   [NSLOT];
  logic [NSLOT-1:0] r_kill, w_kill_d;

  logic            r_bus_cyc, w_bus_cyc_d;
  logic [1:0]      r_bus_slot, w_bus_slot_d;
  logic [TAGW-1:0] r_bus_tag, w_bus_tag_d;

  logic            w_any_avail, w_any_ready, w_arb_en, w_granted, w_issue;
  logic [1:0]      w_avail_idx, w_ready_idx;
  logic [TAGW-1:0] w_req_tag;

  always_comb begin
    w_any_avail = 1'b0;
    w_avail_idx = '0;
    w_any_ready = 1'b0;
    w_ready_idx = '0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      if (!w_any_avail && r_state[s] == DRAMSLOT_AVAIL) begin
        w_any_avail = 1'b1;
        w_avail_idx = 2'(s);
      end
      if (!w_any_ready && r_state[s] == DRAMSLOT_READY) begin
        w_any_ready = 1'b1;
        w_ready_idx = 2'(s);
      end
    end
  end

  assign w_arb_en = w_any_avail && !flush_i;

  qupls_dram_sched_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (w_arb_en),
    .req_i  (req_i),
    .grant_o(grant_o)
  );

  always_comb begin
    w_req_tag = '0;
    for (int unsigned n = 0; n < NREQ; n++) begin
      if (grant_o[n]) w_req_tag = req_tag_i[n*TAGW +: TAGW];
    end
  end

  assign w_granted = |grant_o;
  // Bus frees up either when idle or when the current owner is acked this cycle.
  assign w_issue   = w_any_ready && !flush_i && (!r_bus_cyc || ack_i);

  always_comb begin
    for (int unsigned s = 0; s < NSLOT; s++) begin
      w_state_d[s] = r_state[s];
      w_tag_d[s]   = r_tag[s];
      w_kill_d[s]  = r_kill[s];
      unique case (r_state[s])
        DRAMSLOT_AVAIL: begin
          if (w_granted && w_avail_idx == 2'(s)) begin
            w_state_d[s] = DRAMSLOT_READY;
            w_tag_d[s]   = w_req_tag;
            w_kill_d[s]  = 1'b0;
          end
        end
        DRAMSLOT_READY: begin
          if (flush_i)                             w_state_d[s] = DRAMSLOT_AVAIL;
          else if (w_issue && w_ready_idx == 2'(s)) w_state_d[s] = DRAMSLOT_ACTIVE;
        end
        DRAMSLOT_ACTIVE: begin
          if (flush_i) w_kill_d[s]  = 1'b1;
          if (ack_i)   w_state_d[s] = DRAMSLOT_DELAY;
        end
        DRAMSLOT_DELAY: w_state_d[s] = DRAMSLOT_AVAIL;
      endcase
    end
  end

  always_comb begin
    w_bus_cyc_d  = 1'b0;
    w_bus_slot_d = '0;
    w_bus_tag_d  = '0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      if (w_state_d[s] == DRAMSLOT_ACTIVE) begin
        w_bus_cyc_d  = 1'b1;
        w_bus_slot_d = 2'(s);
        w_bus_tag_d  = w_tag_d[s];
      end
    end
  end

  always_comb begin
    done_o       = 1'b0;
    done_slot_o  = '0;
    done_tag_o   = '0;
    slot_state_o = '0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      slot_state_o[s*2 +: 2] = r_state[s];
      if (r_state[s] == DRAMSLOT_DELAY && !r_kill[s]) begin
        done_o      = 1'b1;
        done_slot_o = 2'(s);
        done_tag_o  = r_tag[s];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < NSLOT; s++) begin
        r_state[s] <= DRAMSLOT_AVAIL;
        r_tag[s]   <= '0;
      end
      r_kill     <= '0;
      r_bus_cyc  <= 1'b0;
      r_bus_slot <= '0;
      r_bus_tag  <= '0;
    end else begin
      for (int unsigned s = 0; s < NSLOT; s++) begin
        r_state[s] <= w_state_d[s];
        r_tag[s]   <= w_tag_d[s];
      end
      r_kill     <= w_kill_d;
      r_bus_cyc  <= w_bus_cyc_d;
      r_bus_slot <= w_bus_slot_d;
      r_bus_tag  <= w_bus_tag_d;
    end
  end

  assign bus_cyc_o  = r_bus_cyc;
  assign bus_slot_o = r_bus_slot;
  assign bus_tag_o  = r_bus_tag;

endmodule

// File: tb/tb_qupls_dram_sched.sv
// Bench for qupls_dram_sched: directed vector table, corner sequences, random vs model.
module tb_qupls_dram_sched;
  import qupls_dram_sched_pkg::*;

  localparam int unsigned NSLOT = 2;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned TAGW  = 6;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic [NREQ-1:0]      req_i = '0;
  logic [NREQ*TAGW-1:0] req_tag_i = '0;
  logic [NREQ-1:0]      grant_o;
  logic                 bus_cyc_o;
  logic [1:0]           bus_slot_o;
  logic [TAGW-1:0]      bus_tag_o;
  logic                 ack_i = 1'b0;
  logic                 flush_i = 1'b0;
  logic                 done_o;
  logic [1:0]           done_slot_o;
  logic [TAGW-1:0]      done_tag_o;
  logic [NSLOT*2-1:0]   slot_state_o;

  always #5 clk = ~clk;

  qupls_dram_sched #(.NSLOT(NSLOT), .NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .req_tag_i   (req_tag_i),
    .grant_o     (grant_o),
    .bus_cyc_o   (bus_cyc_o),
    .bus_slot_o  (bus_slot_o),
    .bus_tag_o   (bus_tag_o),
    .ack_i       (ack_i),
    .flush_i     (flush_i),
    .done_o      (done_o),
    .done_slot_o (done_slot_o),
    .done_tag_o  (done_tag_o),
    .slot_state_o(slot_state_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ*TAGW-1:0] mk_tags(input logic [TAGW-1:0] base);
    logic [NREQ*TAGW-1:0] t;
    for (int n = 0; n < int'(NREQ); n++) t[n*TAGW +: TAGW] = base + TAGW'(n);
    return t;
  endfunction

  function automatic logic [1:0] st_of(input int s);
    return slot_state_o[s*2 +: 2];
  endfunction

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic apply(input logic [NREQ-1:0] req, input logic [NREQ*TAGW-1:0] tags,
                       input logic ack, input logic flush, input logic rst_v);
    @(negedge clk);
    req_i = req; req_tag_i = tags; ack_i = ack; flush_i = flush; rst_i = rst_v;
    #1;
  endtask

  task automatic do_reset();
    apply('0, '0, 1'b0, 1'b0, 1'b1);
    apply('0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- behavioural model ----------------
  dram_state_t     m_st   [NSLOT];
  logic [TAGW-1:0] m_tag  [NSLOT];
  bit              m_kill [NSLOT];
  int              m_rr, m_owner;

  function automatic void model_reset();
    for (int s = 0; s < int'(NSLOT); s++) begin
      m_st[s] = DRAMSLOT_AVAIL; m_tag[s] = '0; m_kill[s] = 0;
    end
    m_rr = 0; m_owner = -1;
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] req, input logic flush);
    bit any_free = 0;
    for (int s = 0; s < int'(NSLOT); s++) if (m_st[s] == DRAMSLOT_AVAIL) any_free = 1;
    if (flush || !any_free) return -1;
    for (int k = 0; k < int'(NREQ); k++) begin
      int n = (m_rr + k) % int'(NREQ);
      if (req[n]) return n;
    end
    return -1;
  endfunction

  task automatic model_check(input logic [NREQ-1:0] req, input logic flush);
    int g = model_grant(req, flush);
    logic [NREQ-1:0] eg = '0;
    bit ed = 0;
    int eds = 0;
    if (g >= 0) eg[g] = 1'b1;
    chk("rnd_grant", 32'(grant_o), 32'(eg));
    chk("rnd_bus_cyc", 32'(bus_cyc_o), 32'(m_owner >= 0));
    if (m_owner >= 0) begin
      chk("rnd_bus_slot", 32'(bus_slot_o), 32'(m_owner));
      chk("rnd_bus_tag", 32'(bus_tag_o), 32'(m_tag[m_owner]));
    end
    for (int s = 0; s < int'(NSLOT); s++) begin
      chk("rnd_state", 32'(st_of(s)), 32'(m_st[s]));
      if (m_st[s] == DRAMSLOT_DELAY && !m_kill[s]) begin ed = 1; eds = s; end
    end
    chk("rnd_done", 32'(done_o), 32'(ed));
    if (ed) begin
      chk("rnd_done_slot", 32'(done_slot_o), 32'(eds));
      chk("rnd_done_tag", 32'(done_tag_o), 32'(m_tag[eds]));
    end
  endtask

  function automatic void model_step(input logic [NREQ-1:0] req, input logic [NREQ*TAGW-1:0] tags,
                                     input logic ack, input logic flush, input logic rst_v);
    dram_state_t prev [NSLOT];
    int g, gs;
    if (rst_v) begin model_reset(); return; end
    g = model_grant(req, flush);
    gs = -1;
    for (int s = int'(NSLOT) - 1; s >= 0; s--) if (m_st[s] == DRAMSLOT_AVAIL) gs = s;
    prev = m_st;
    for (int s = 0; s < int'(NSLOT); s++) begin
      if (prev[s] == DRAMSLOT_DELAY) m_st[s] = DRAMSLOT_AVAIL;
      if (flush && prev[s] == DRAMSLOT_READY) m_st[s] = DRAMSLOT_AVAIL;
    end
    if (flush && m_owner >= 0) m_kill[m_owner] = 1;
    if (m_owner >= 0 && ack) begin m_st[m_owner] = DRAMSLOT_DELAY; m_owner = -1; end
    if (m_owner < 0 && !flush) begin
      for (int s = 0; s < int'(NSLOT); s++) begin
        if (m_owner < 0 && prev[s] == DRAMSLOT_READY) begin
          m_st[s] = DRAMSLOT_ACTIVE; m_owner = s;
        end
      end
    end
    if (g >= 0) begin
      m_st[gs] = DRAMSLOT_READY; m_tag[gs] = tags[g*TAGW +: TAGW]; m_kill[gs] = 0;
      m_rr = (g + 1) % int'(NREQ);
    end
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0] req; logic [5:0] base; logic ack; logic flush;
    logic [3:0] grant; logic cyc; logic [5:0] btag; logic done; logic [5:0] dtag;
    logic [1:0] s0;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int gq [$];
    int bq [$];
    int nact;
    logic [NREQ-1:0] rq;
    logic [NREQ*TAGW-1:0] rt;
    logic ra, rf, rr_v;

    // Single request, then flush coincident with a request.
    tbl[0]  = '{4'b0001, 6'h05, 1'b0, 1'b0, 4'b0001, 1'b0, 6'h00, 1'b0, 6'h00, DRAMSLOT_AVAIL};
    tbl[1]  = '{4'b0000, 6'h05, 1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 1'b0, 6'h00, DRAMSLOT_READY};
    tbl[2]  = '{4'b0000, 6'h05, 1'b1, 1'b0, 4'b0000, 1'b1, 6'h05, 1'b0, 6'h00, DRAMSLOT_ACTIVE};
    tbl[3]  = '{4'b0000, 6'h05, 1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 1'b1, 6'h05, DRAMSLOT_DELAY};
    tbl[4]  = '{4'b0000, 6'h05, 1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 1'b0, 6'h00, DRAMSLOT_AVAIL};
    tbl[5]  = '{4'b0011, 6'h10, 1'b0, 1'b1, 4'b0000, 1'b0, 6'h00, 1'b0, 6'h00, DRAMSLOT_AVAIL};
    tbl[6]  = '{4'b0011, 6'h10, 1'b0, 1'b0, 4'b0010, 1'b0, 6'h00, 1'b0, 6'h00, DRAMSLOT_AVAIL};
    tbl[7]  = '{4'b0000, 6'h10, 1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 1'b0, 6'h00, DRAMSLOT_READY};
    tbl[8]  = '{4'b0000, 6'h10, 1'b1, 1'b0, 4'b0000, 1'b1, 6'h11, 1'b0, 6'h00, DRAMSLOT_ACTIVE};
    tbl[9]  = '{4'b0000, 6'h10, 1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 1'b1, 6'h11, DRAMSLOT_DELAY};
    tbl[10] = '{4'b0000, 6'h10, 1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 1'b0, 6'h00, DRAMSLOT_AVAIL};

    do_reset();
    apply('0, '0, 1'b0, 1'b0, 1'b0);
    chk("reset_state", 32'(slot_state_o), 32'(0));
    chk("reset_bus", 32'({bus_cyc_o, bus_slot_o, bus_tag_o}), 32'(0));
    chk("reset_done", 32'({done_o, done_slot_o, done_tag_o}), 32'(0));
    chk("reset_grant", 32'(grant_o), 32'(0));

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].req, mk_tags(tbl[i].base), tbl[i].ack, tbl[i].flush, 1'b0);
      chk($sformatf("vec%0d_grant", i), 32'(grant_o), 32'(tbl[i].grant));
      chk($sformatf("vec%0d_cyc", i), 32'(bus_cyc_o), 32'(tbl[i].cyc));
      if (tbl[i].cyc) begin
        chk($sformatf("vec%0d_bslot", i), 32'(bus_slot_o), 32'(0));
        chk($sformatf("vec%0d_btag", i), 32'(bus_tag_o), 32'(tbl[i].btag));
      end
      chk($sformatf("vec%0d_done", i), 32'(done_o), 32'(tbl[i].done));
      if (tbl[i].done) begin
        chk($sformatf("vec%0d_dslot", i), 32'(done_slot_o), 32'(0));
        chk($sformatf("vec%0d_dtag", i), 32'(done_tag_o), 32'(tbl[i].dtag));
      end
      chk($sformatf("vec%0d_s0", i), 32'(st_of(0)), 32'(tbl[i].s0));
      chk($sformatf("vec%0d_s1", i), 32'(st_of(1)), 32'(DRAMSLOT_AVAIL));
    end

    // Round-robin with all requesters asserted and ack always high.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      apply(4'hF, mk_tags(6'h08), 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < int'(NREQ); n++) if (grant_o[n]) gq.push_back(n);
      if (bus_cyc_o) bq.push_back(int'(bus_slot_o));
      nact = 0;
      for (int s = 0; s < int'(NSLOT); s++) if (st_of(s) == DRAMSLOT_ACTIVE) nact++;
      chk("rr_one_active", 32'(nact <= 1), 32'(1));
    end
    chk("rr_grant_count", 32'(gq.size() >= 5), 32'(1));
    for (int i = 0; i < 5 && i < gq.size(); i++) chk("rr_order", 32'(gq[i]), 32'(i % 4));
    chk("rr_bus_count", 32'(bq.size() >= 4), 32'(1));
    if (bq.size() > 0) chk("rr_bus_first", 32'(bq[0]), 32'(0));
    for (int i = 1; i < bq.size(); i++) chk("rr_bus_alt", 32'(bq[i]), 32'(1 - bq[i-1]));

    // Both slots busy, ack withheld.
    do_reset();
    apply(4'b0011, mk_tags(6'h20), 1'b0, 1'b0, 1'b0);
    chk("full_g0", 32'(grant_o), 32'(4'b0001));
    apply(4'b0011, mk_tags(6'h20), 1'b0, 1'b0, 1'b0);
    chk("full_g1", 32'(grant_o), 32'(4'b0010));
    for (int c = 0; c < 4; c++) begin
      apply(4'b0011, mk_tags(6'h20), 1'b0, 1'b0, 1'b0);
      chk("full_blocked", 32'(grant_o), 32'(0));
    end
    chk("full_s0", 32'(st_of(0)), 32'(DRAMSLOT_ACTIVE));
    chk("full_s1", 32'(st_of(1)), 32'(DRAMSLOT_READY));
    apply(4'b0011, mk_tags(6'h20), 1'b1, 1'b0, 1'b0);
    chk("full_ack_blocked", 32'(grant_o), 32'(0));
    chk("full_ack_tag", 32'(bus_tag_o), 32'(6'h20));
    apply(4'b0011, mk_tags(6'h20), 1'b0, 1'b0, 1'b0);
    chk("full_delay_blocked", 32'(grant_o), 32'(0));
    chk("full_handoff_slot", 32'({bus_cyc_o, bus_slot_o}), 32'({1'b1, 2'd1}));
    apply(4'b0011, mk_tags(6'h20), 1'b0, 1'b0, 1'b0);
    chk("full_resume", 32'(grant_o), 32'(4'b0001));

    // Flush with slot 0 ACTIVE and slot 1 READY.
    do_reset();
    apply(4'b0001, mk_tags(6'h30), 1'b0, 1'b0, 1'b0);
    apply(4'b0010, mk_tags(6'h30), 1'b0, 1'b0, 1'b0);
    chk("flush_pre_grant", 32'(grant_o), 32'(4'b0010));
    apply('0, '0, 1'b0, 1'b1, 1'b0);
    chk("flush_pre_s0", 32'(st_of(0)), 32'(DRAMSLOT_ACTIVE));
    chk("flush_pre_s1", 32'(st_of(1)), 32'(DRAMSLOT_READY));
    apply('0, '0, 1'b0, 1'b0, 1'b0);
    chk("flush_s1_avail", 32'(st_of(1)), 32'(DRAMSLOT_AVAIL));
    chk("flush_s0_active", 32'(st_of(0)), 32'(DRAMSLOT_ACTIVE));
    apply('0, '0, 1'b0, 1'b0, 1'b0);
    apply('0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_ack_cyc", 32'(bus_cyc_o), 32'(1));
    for (int c = 0; c < 2; c++) begin
      apply('0, '0, 1'b0, 1'b0, 1'b0);
      chk("flush_no_done", 32'(done_o), 32'(0));
    end
    chk("flush_s0_avail", 32'(st_of(0)), 32'(DRAMSLOT_AVAIL));

    // Reset while a slot is ACTIVE.
    do_reset();
    apply(4'b0001, mk_tags(6'h3A), 1'b0, 1'b0, 1'b0);
    apply('0, '0, 1'b0, 1'b0, 1'b0);
    apply('0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_pre_cyc", 32'(bus_cyc_o), 32'(1));
    apply('0, '0, 1'b1, 1'b0, 1'b0);
    chk("rst_states", 32'(slot_state_o), 32'(0));
    chk("rst_cyc", 32'(bus_cyc_o), 32'(0));
    chk("rst_done", 32'(done_o), 32'(0));
    apply('0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_late_done", 32'(done_o), 32'(0));
    chk("rst_late_states", 32'(slot_state_o), 32'(0));

    // Random traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rq   = NREQ'($urandom);
      rt   = (NREQ*TAGW)'({$urandom, $urandom});
      ra   = 1'($urandom_range(0, 1));
      rf   = ($urandom_range(0, 9) == 0);
      rr_v = ($urandom_range(0, 99) == 0);
      apply(rq, rt, ra, rf, rr_v);
      model_check(rq, rf);
      model_step(rq, rt, ra, rf, rr_v);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
